// File: rtl/control_unit.sv
// Moore FSM controller for a multicycle MIPS-subset datapath (R-type, lw, sw, beq, addi, j).
// Sequences fetch/decode/execute/memory/writeback and decodes all mux selects and strobes from state.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [3:0] state,
  output logic [3:0] nextstate,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] aluop,
  output logic [1:0] PCsrc,
  output logic       PCwrite,
  output logic       branch,
  output logic       jump,
  output logic       PCEn
);

  localparam int unsigned OpW = 6;
  localparam int unsigned StW = 4;

  localparam logic [OpW-1:0] OpR    = 6'b000000;
  localparam logic [OpW-1:0] OpLw   = 6'b100011;
  localparam logic [OpW-1:0] OpSw   = 6'b101011;
  localparam logic [OpW-1:0] OpBeq  = 6'b000100;
  localparam logic [OpW-1:0] OpAddi = 6'b001000;
  localparam logic [OpW-1:0] OpJ    = 6'b000010;

  typedef enum logic [StW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OpLw, OpSw: state_d = S_MEMADR;
          OpR:        state_d = S_EXEC;
          OpBeq:      state_d = S_BRANCH;
          OpAddi:     state_d = S_ADDIEX;
          OpJ:        state_d = S_JUMP;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OpSw) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode; everything is held low while reset is asserted
  always_comb begin
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    alusrcA  = 2'b00;
    alusrcB  = 2'b00;
    aluop    = 2'b00;
    PCsrc    = 2'b00;
    PCwrite  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          IRWrite = 1'b1;
          alusrcB = 2'b01;
          PCwrite = 1'b1;
        end
        S_DECODE: alusrcB = 2'b11;
        S_MEMADR: begin
          alusrcA = 2'b01;
          alusrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          memread = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXEC: begin
          alusrcA = 2'b01;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrcA = 2'b01;
          aluop   = 2'b01;
          PCsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_ADDIEX: begin
          alusrcA = 2'b01;
          alusrcB = 2'b10;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          PCsrc   = 2'b10;
          jump    = 1'b1;
          PCwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The gated copy of nextstate is export-only, so reset never reaches a flop D input
  assign state     = state_q;
  assign nextstate = rst ? state_d : S_FETCH;
  assign PCEn      = PCwrite | (branch & zero);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: walks each instruction's state sequence
// and checks state, nextstate, every control output and PCEn against hand-derived values.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic [3:0] state, nextstate;
  logic       regdst, memtoreg, regwrite, memread, memwrite, IorD, IRWrite;
  logic [1:0] alusrcA, alusrcB, aluop, PCsrc;
  logic       PCwrite, branch, jump, PCEn;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       regdst, memtoreg, regwrite, memread, memwrite, iord, irwrite;
    logic [1:0] alusrca, alusrcb, aluop, pcsrc;
    logic       pcwrite, branch, jump;
  } ctrl_t;

  ctrl_t act;
  always_comb act = {regdst, memtoreg, regwrite, memread, memwrite, IorD, IRWrite,
                     alusrcA, alusrcB, aluop, PCsrc, PCwrite, branch, jump};

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .state(state), .nextstate(nextstate),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .IorD(IorD), .IRWrite(IRWrite), .alusrcA(alusrcA),
    .alusrcB(alusrcB), .aluop(aluop), .PCsrc(PCsrc), .PCwrite(PCwrite),
    .branch(branch), .jump(jump), .PCEn(PCEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word per state, written from the output table
  function automatic ctrl_t exp_ctrl(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1; end
      4'd1:  c.alusrcb = 2'b11;
      4'd2:  begin c.alusrca = 2'b01; c.alusrcb = 2'b10; end
      4'd3:  begin c.iord = 1; c.memread = 1; end
      4'd4:  begin c.regwrite = 1; c.memtoreg = 1; end
      4'd5:  begin c.iord = 1; c.memwrite = 1; end
      4'd6:  begin c.alusrca = 2'b01; c.aluop = 2'b10; end
      4'd7:  begin c.regdst = 1; c.regwrite = 1; end
      4'd8:  begin c.alusrca = 2'b01; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; end
      4'd9:  begin c.alusrca = 2'b01; c.alusrcb = 2'b10; end
      4'd10: c.regwrite = 1;
      4'd11: begin c.pcsrc = 2'b10; c.jump = 1; c.pcwrite = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b0; opcode = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      opcode = (i % 2 == 0) ? 6'b000100 : 6'b000000;
      zero   = ~zero;
      #1;
      n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_chk++; if (nextstate !== 4'd0) begin n_fail++; $display("FAIL reset_next: got %0d want 0", nextstate); end
      n_chk++; if (act !== ctrl_t'('0)) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", act); end
      n_chk++; if (PCEn !== 1'b0) begin n_fail++; $display("FAIL reset_pcen: got %b want 0", PCEn); end
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_beq();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    for (int pass = 0; pass < 2; pass++) begin
      opcode = 6'b000100; zero = (pass == 0); #1;
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (state !== seq[i]) begin n_fail++; $display("FAIL beq_state z=%0b step %0d: got %0d want %0d", zero, i, state, seq[i]); end
        n_chk++; if (nextstate !== seq[i+1]) begin n_fail++; $display("FAIL beq_next z=%0b step %0d: got %0d want %0d", zero, i, nextstate, seq[i+1]); end
        n_chk++; if (act !== exp_ctrl(seq[i])) begin n_fail++; $display("FAIL beq_ctrl z=%0b step %0d: got %h want %h", zero, i, act, exp_ctrl(seq[i])); end
        n_chk++; if (PCEn !== ((i == 0) || (i == 2 && zero))) begin n_fail++; $display("FAIL beq_pcen z=%0b step %0d: got %b", zero, i, PCEn); end
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_rtype();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; zero = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (state !== seq[i]) begin n_fail++; $display("FAIL r_state step %0d: got %0d want %0d", i, state, seq[i]); end
      n_chk++; if (nextstate !== seq[i+1]) begin n_fail++; $display("FAIL r_next step %0d: got %0d want %0d", i, nextstate, seq[i+1]); end
      n_chk++; if (act !== exp_ctrl(seq[i])) begin n_fail++; $display("FAIL r_ctrl step %0d: got %h want %h", i, act, exp_ctrl(seq[i])); end
      n_chk++; if (PCEn !== (i == 0)) begin n_fail++; $display("FAIL r_pcen step %0d: got %b want %b", i, PCEn, (i == 0)); end
      if (i == 3) begin
        n_chk++; if ({regdst, regwrite} !== 2'b11) begin n_fail++; $display("FAIL r_aluwb: got %b want 11", {regdst, regwrite}); end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_memory();
    logic [3:0] lw_seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [3:0] sw_seq [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0};
    logic [3:0] s, sn;
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      opcode = (pass == 0) ? 6'b100011 : 6'b101011; zero = 1'b0; #1;
      n = (pass == 0) ? 5 : 4;
      for (int i = 0; i < n; i++) begin
        s  = (pass == 0) ? lw_seq[i] : sw_seq[i];
        sn = (pass == 0) ? lw_seq[i+1] : sw_seq[i+1];
        n_chk++; if (state !== s) begin n_fail++; $display("FAIL mem%0d_state step %0d: got %0d want %0d", pass, i, state, s); end
        n_chk++; if (nextstate !== sn) begin n_fail++; $display("FAIL mem%0d_next step %0d: got %0d want %0d", pass, i, nextstate, sn); end
        n_chk++; if (act !== exp_ctrl(s)) begin n_fail++; $display("FAIL mem%0d_ctrl step %0d: got %h want %h", pass, i, act, exp_ctrl(s)); end
        n_chk++; if (PCEn !== (i == 0)) begin n_fail++; $display("FAIL mem%0d_pcen step %0d: got %b", pass, i, PCEn); end
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_addi_j_illegal();
    logic [5:0] ops [3] = '{6'b001000, 6'b000010, 6'b111111};
    logic [3:0] seq [3][5] = '{'{4'd0, 4'd1, 4'd9, 4'd10, 4'd0},
                              '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0},
                              '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0}};
    int lens [3] = '{4, 3, 2};
    for (int t = 0; t < 3; t++) begin
      opcode = ops[t]; zero = 1'b1; #1;
      for (int i = 0; i < lens[t]; i++) begin
        n_chk++; if (state !== seq[t][i]) begin n_fail++; $display("FAIL op%b_state step %0d: got %0d want %0d", ops[t], i, state, seq[t][i]); end
        n_chk++; if (nextstate !== seq[t][i+1]) begin n_fail++; $display("FAIL op%b_next step %0d: got %0d want %0d", ops[t], i, nextstate, seq[t][i+1]); end
        n_chk++; if (act !== exp_ctrl(seq[t][i])) begin n_fail++; $display("FAIL op%b_ctrl step %0d: got %h want %h", ops[t], i, act, exp_ctrl(seq[t][i])); end
        n_chk++; if (PCEn !== (i == 0 || seq[t][i] == 4'd11)) begin n_fail++; $display("FAIL op%b_pcen step %0d: got %b", ops[t], i, PCEn); end
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_async_reset();
    opcode = 6'b100011; zero = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    n_chk++; if (state !== 4'd3) begin n_fail++; $display("FAIL ar_memrd: got %0d want 3", state); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL ar_state: got %0d want 0", state); end
    n_chk++; if (nextstate !== 4'd0) begin n_fail++; $display("FAIL ar_next: got %0d want 0", nextstate); end
    n_chk++; if (act !== ctrl_t'('0) || PCEn !== 1'b0) begin n_fail++; $display("FAIL ar_ctrl: got %h pcen %b want 0", act, PCEn); end
    @(negedge clk); #1;
    n_chk++; if (state !== 4'd0 || act !== ctrl_t'('0)) begin n_fail++; $display("FAIL ar_hold: state %0d ctrl %h want 0/0", state, act); end
    rst = 1'b1; #1;
    n_chk++; if (state !== 4'd0 || act !== exp_ctrl(4'd0) || PCEn !== 1'b1) begin n_fail++; $display("FAIL ar_fetch: state %0d ctrl %h pcen %b", state, act, PCEn); end
    @(negedge clk); #1;
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL ar_decode: got %0d want 1", state); end
  endtask

  initial begin
    rst = 1'b0; opcode = 6'b000000; zero = 1'b0;
    test_reset();
    test_beq();
    test_rtype();
    test_memory();
    test_addi_j_illegal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
